// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Handshaked single-outstanding load/store unit. Issues aligned bus
//            requests with byte strobes, formats load data (extend, LWL/LWR).
//            Optional define MEM_ALIGN_CHECK_EN: misaligned LH/LHU/SH/LW/SW error.
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int OFS_W  = $clog2(STRB_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_rt,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_strb,
  input  logic              mem_rdata_valid,
  output logic              mem_rdata_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_err
);

  localparam logic [3:0] OP_LB  = 4'd0,  OP_LH  = 4'd1,  OP_LW  = 4'd2,  OP_LBU = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4,  OP_LWL = 4'd5,  OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8,  OP_SH  = 4'd9,  OP_SW  = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11, OP_SWR = 4'd12;
  // Clears the in-word byte bits of a lane index; zero on a 32-bit bus.
  localparam logic [OFS_W-1:0] WORD_LANE_MASK = {OFS_W{1'b1}} << 2;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2, ST_WB = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         rt_q, rt_d;
  logic [4:0]          rd_q, rd_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                wb_we_q, wb_we_d;
  logic                wb_err_q, wb_err_d;

  logic [OFS_W-1:0]    in_lane, in_word;
  logic [1:0]          in_b;
  logic [3:0]          st_wstrb;
  logic [31:0]         st_wword;
  logic                in_illegal, in_misalign, in_err;

  always_comb begin
    in_lane  = req_addr[OFS_W-1:0];
    in_word  = in_lane & WORD_LANE_MASK;
    in_b     = req_addr[1:0];
    st_wstrb = 4'b0000;
    st_wword = 32'h0;
    case (req_op)
      OP_SB:  begin st_wstrb = 4'b0001 << in_b;           st_wword = {4{req_rt[7:0]}};  end
      OP_SH:  begin st_wstrb = 4'b0011 << {in_b[1], 1'b0}; st_wword = {2{req_rt[15:0]}}; end
      OP_SW:  begin st_wstrb = 4'b1111;                    st_wword = req_rt;            end
      OP_SWL: begin
        st_wstrb = 4'b1111 >> (2'd3 - in_b);
        st_wword = req_rt >> {2'd3 - in_b, 3'b000};
      end
      OP_SWR: begin
        st_wstrb = 4'b1111 << in_b;
        st_wword = req_rt << {in_b, 3'b000};
      end
      default: ;
    endcase
    in_illegal = (req_op == 4'd7) || (req_op >= 4'd13);
`ifdef MEM_ALIGN_CHECK_EN
    in_misalign = (((req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH)) && req_addr[0]) ||
                  (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00));
`else
    in_misalign = 1'b0;
`endif
    in_err = in_illegal || in_misalign;
  end

  logic [OFS_W-1:0]    ld_lane, ld_word, ld_half;
  logic [1:0]          ld_b;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_hword;
  logic [31:0]         ld_m, ld_fmt;

  always_comb begin
    ld_lane  = addr_q[OFS_W-1:0];
    ld_word  = ld_lane & WORD_LANE_MASK;
    ld_half  = {ld_lane[OFS_W-1:1], 1'b0};
    ld_b     = addr_q[1:0];
    ld_byte  = 8'(mem_rdata >> {ld_lane, 3'b000});
    ld_hword = 16'(mem_rdata >> {ld_half, 3'b000});
    ld_m     = 32'(mem_rdata >> {ld_word, 3'b000});
    ld_fmt   = 32'h0;
    case (op_q)
      OP_LB:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: ld_fmt = {24'h0, ld_byte};
      OP_LH:  ld_fmt = {{16{ld_hword[15]}}, ld_hword};
      OP_LHU: ld_fmt = {16'h0, ld_hword};
      OP_LW:  ld_fmt = ld_m;
      OP_LWL: begin
        case (ld_b)
          2'd0:    ld_fmt = {ld_m[7:0],  rt_q[23:0]};
          2'd1:    ld_fmt = {ld_m[15:0], rt_q[15:0]};
          2'd2:    ld_fmt = {ld_m[23:0], rt_q[7:0]};
          default: ld_fmt = ld_m;
        endcase
      end
      OP_LWR: begin
        case (ld_b)
          2'd0:    ld_fmt = ld_m;
          2'd1:    ld_fmt = {rt_q[31:24], ld_m[31:8]};
          2'd2:    ld_fmt = {rt_q[31:16], ld_m[31:16]};
          default: ld_fmt = {rt_q[31:8],  ld_m[31:24]};
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;
    wb_we_d   = wb_we_q;
    wb_err_d  = wb_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          addr_d    = req_addr;
          rt_d      = req_rt;
          rd_d      = req_rd;
          wb_data_d = 32'h0;
          wb_we_d   = 1'b0;
          wb_err_d  = in_err;
          strb_d    = '0;
          wdata_d   = '0;
          if (in_err) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_REQ;
            if (req_op[3]) begin
              strb_d  = STRB_W'(st_wstrb) << in_word;
              wdata_d = DATA_W'(st_wword) << {in_word, 3'b000};
            end else begin
              strb_d  = '1;
            end
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) state_d = op_q[3] ? ST_WB : ST_RESP;
      end
      ST_RESP: begin
        if (mem_rdata_valid) begin
          wb_data_d = ld_fmt;
          wb_we_d   = 1'b1;
          state_d   = ST_WB;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          wb_we_d  = 1'b0;
          wb_err_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= 4'd0;
      addr_q    <= '0;
      rt_q      <= 32'h0;
      rd_q      <= 5'd0;
      strb_q    <= '0;
      wdata_q   <= '0;
      wb_data_q <= 32'h0;
      wb_we_q   <= 1'b0;
      wb_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
      wb_we_q   <= wb_we_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign req_ready       = (state_q == ST_IDLE);
  assign mem_req_valid   = (state_q == ST_REQ);
  assign mem_rdata_ready = (state_q == ST_RESP);
  assign wb_valid        = (state_q == ST_WB);
  assign mem_wen         = op_q[3];
  assign mem_addr        = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign mem_wdata       = wdata_q;
  assign mem_strb        = strb_q;
  assign wb_we           = wb_we_q;
  assign wb_rd           = rd_q;
  assign wb_data         = wb_data_q;
  assign wb_err          = wb_err_q;

endmodule
`default_nettype wire
